conv_result_writer: RTL

Downstream stage of the convolutional layer. Accepts one beat per cycle of `UNROLL` packed result lanes under a valid/enable handshake and buffers beats in a small FIFO. Drains them as 32-bit words to a feature-map memory write port with an auto-incrementing address, then signals per-image completion. Its `conv_enable` output drives the layer's output-enable input and provides backpressure.

---
 rtl/conv_result_writer.sv | 104 ++++++++++
 1 files changed

// File: rtl/conv_result_writer.sv
// Convolution result writer: buffers packed result beats in a small FIFO and
// drains them as words to feature-map memory at an auto-incrementing address.
module conv_result_writer #(
  parameter int UNROLL     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [15:0]                  out_count,
  input  logic [UNROLL*DATA_WIDTH-1:0] conv_result,
  input  logic                         conv_valid,
  output logic                         conv_enable,
  output logic                         mem_wr_en,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [31:0]                  mem_wr_data,
  input  logic                         mem_wr_ready,
  output logic                         busy,
  output logic                         done
);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                          state;
  logic [ADDR_WIDTH-1:0]               base_q;
  logic [15:0]                         count_q;
  logic [15:0]                         accepted;
  logic [15:0]                         written;
  logic [PW:0]                         wr_ptr;
  logic [PW:0]                         rd_ptr;
  logic [UNROLL-1:0][DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
  logic [UNROLL-1:0][DATA_WIDTH-1:0]   head;
  logic                                fifo_empty;
  logic                                fifo_full;
  logic                                push;
  logic                                pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign conv_enable = (state == S_RUN) && !fifo_full;
  assign mem_wr_en   = ((state == S_RUN) || (state == S_DRAIN)) && !fifo_empty;
  assign push        = conv_valid && conv_enable;
  assign pop         = mem_wr_en && mem_wr_ready;

  assign head        = fifo_mem[rd_ptr[PW-1:0]];
  // Data is gated so stale FIFO contents never appear on the bus while idle.
  assign mem_wr_data = mem_wr_en ? head : '0;
  assign mem_addr    = base_q + ADDR_WIDTH'(written);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= conv_result;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      base_q   <= '0;
      count_q  <= '0;
      accepted <= '0;
      written  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        accepted <= accepted + 16'd1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        written <= written + 16'd1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            count_q  <= out_count;
            accepted <= '0;
            written  <= '0;
            state    <= (out_count == 16'd0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (push && (accepted + 16'd1 == count_q)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          // All beats are already pushed, so the final pop also empties the FIFO.
          if (pop && (written + 16'd1 == count_q)) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
